// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator sharing one prescaled timebase, with edge- or
// centre-aligned counting and shadowed period, mode and duty registers.
module pwm_multi_channel #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int PSC_W    = 8,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PSC_W-1:0]    prescale,
   input  logic [WIDTH-1:0]    period,
   input  logic                center_mode,
   input  logic                duty_wr_en,
   input  logic [CH_W-1:0]     duty_wr_ch,
   input  logic [WIDTH-1:0]    duty_wr_data,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_end
);

   logic [PSC_W-1:0] r_psc;
   logic [WIDTH-1:0] r_cnt;
   logic             r_down;

   logic [WIDTH-1:0] r_periodShadow;
   logic [WIDTH-1:0] r_periodAct;
   logic             r_modeShadow;
   logic             r_modeAct;
   logic [WIDTH-1:0] r_dutyShadow [CHANNELS];
   logic [WIDTH-1:0] r_dutyAct    [CHANNELS];

   logic             w_tick;
   logic             w_boundary;

   // A boundary is the tick whose next count is 0; P<=1 in centre mode has no down leg.
   always_comb begin
      w_tick     = enable && (r_psc == prescale);
      w_boundary = 1'b0;
      if (r_modeAct) begin
         w_boundary = (r_down && (r_cnt == WIDTH'(1))) ||
                      (!r_down && (r_cnt == r_periodAct) && (r_periodAct <= WIDTH'(1)));
      end else begin
         w_boundary = (r_cnt == r_periodAct);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_periodShadow <= '0;
         r_modeShadow   <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_dutyShadow[i] <= '0;
         end
      end else begin
         r_periodShadow <= period;
         r_modeShadow   <= center_mode;
         for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr_en && (duty_wr_ch == CH_W'(i))) begin
               r_dutyShadow[i] <= duty_wr_data;
            end
         end
      end
   end

   // Active copies follow the shadows while stopped, otherwise only at a boundary tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_periodAct <= '0;
         r_modeAct   <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_dutyAct[i] <= '0;
         end
      end else if (!enable || (w_tick && w_boundary)) begin
         r_periodAct <= r_periodShadow;
         r_modeAct   <= r_modeShadow;
         for (int i = 0; i < CHANNELS; i++) begin
            r_dutyAct[i] <= r_dutyShadow[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_psc  <= '0;
         r_cnt  <= '0;
         r_down <= 1'b0;
      end else if (!enable) begin
         r_psc  <= '0;
         r_cnt  <= '0;
         r_down <= 1'b0;
      end else begin
         r_psc <= w_tick ? '0 : r_psc + PSC_W'(1);
         if (w_tick) begin
            if (w_boundary) begin
               r_cnt  <= '0;
               r_down <= 1'b0;
            end else if (r_modeAct && r_down) begin
               r_cnt <= r_cnt - WIDTH'(1);
            end else if (r_modeAct && (r_cnt == r_periodAct)) begin
               r_down <= 1'b1;
               r_cnt  <= r_cnt - WIDTH'(1);
            end else begin
               r_cnt <= r_cnt + WIDTH'(1);
            end
         end
      end
   end

   // Outputs compare the count before its update, so they trail it by one clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out    <= '0;
         period_end <= 1'b0;
      end else if (!enable) begin
         pwm_out    <= '0;
         period_end <= 1'b0;
      end else begin
         period_end <= w_tick && w_boundary;
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] <= (r_cnt < r_dutyAct[i]);
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Testbench for pwm_multi_channel: directed scenarios plus randomized traffic,
// all checked against a period/phase reference model.
module tb_pwm_multi_channel;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int PSC_W    = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic [PSC_W-1:0]    prescale;
   logic [WIDTH-1:0]    period;
   logic                center_mode;
   logic                duty_wr_en;
   logic [1:0]          duty_wr_ch;
   logic [WIDTH-1:0]    duty_wr_data;
   logic [CHANNELS-1:0] pwm_out;
   logic                period_end;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: position within the period plus shadow/active settings.
   int                  mPhase;
   int                  mPsc;
   int                  mP;
   bit                  mMode;
   int                  mDuty [CHANNELS];
   int                  sP;
   bit                  sMode;
   int                  sDuty [CHANNELS];
   logic [CHANNELS-1:0] mOut;
   logic                mPend;

   always #5 clk = ~clk;

   pwm_multi_channel #(
      .WIDTH(WIDTH),
      .CHANNELS(CHANNELS),
      .PSC_W(PSC_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .prescale(prescale),
      .period(period),
      .center_mode(center_mode),
      .duty_wr_en(duty_wr_en),
      .duty_wr_ch(duty_wr_ch),
      .duty_wr_data(duty_wr_data),
      .pwm_out(pwm_out),
      .period_end(period_end)
   );

   task automatic modelReset();
      mPhase = 0; mPsc = 0; mP = 0; mMode = 0; sP = 0; sMode = 0;
      mOut = '0; mPend = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         mDuty[i] = 0;
         sDuty[i] = 0;
      end
   endtask

   // Advance the model by one clk using the inputs about to be sampled, then step the DUT.
   task automatic applyStimulus();
      int  nP;
      bit  nMode;
      int  nDuty [CHANNELS];
      int  len;
      int  cntv;
      bit  tick;
      bit  wrap;
      nP    = int'(period);
      nMode = center_mode;
      nDuty = sDuty;
      if (duty_wr_en) nDuty[duty_wr_ch] = int'(duty_wr_data);
      if (!enable) begin
         mPhase = 0; mPsc = 0; mOut = '0; mPend = 1'b0;
         mP = sP; mMode = sMode; mDuty = sDuty;
      end else begin
         tick = (mPsc == int'(prescale));
         len  = mMode ? ((mP == 0) ? 1 : 2 * mP) : mP + 1;
         cntv = (!mMode || mPhase <= mP) ? mPhase : 2 * mP - mPhase;
         for (int i = 0; i < CHANNELS; i++) mOut[i] = (cntv < mDuty[i]);
         wrap  = tick && (mPhase + 1 == len);
         mPend = wrap;
         mPsc  = tick ? 0 : (mPsc + 1) % 256;
         if (tick) begin
            mPhase = wrap ? 0 : mPhase + 1;
            if (wrap) begin
               mP = sP; mMode = sMode; mDuty = sDuty;
            end
         end
      end
      sP = nP; sMode = nMode; sDuty = nDuty;
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input int p, input bit cm, input int psc,
                            input int d0, input int d1, input int d2, input int d3);
      int d [CHANNELS];
      d = '{d0, d1, d2, d3};
      enable      = 1'b0;
      period      = WIDTH'(p);
      center_mode = cm;
      prescale    = PSC_W'(psc);
      for (int i = 0; i < CHANNELS; i++) begin
         duty_wr_en   = 1'b1;
         duty_wr_ch   = 2'(i);
         duty_wr_data = WIDTH'(d[i]);
         applyStimulus();
      end
      duty_wr_en = 1'b0;
      applyStimulus();
      applyStimulus();
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; prescale = '0; period = '0; center_mode = 1'b0;
      duty_wr_en = 1'b0; duty_wr_ch = '0; duty_wr_data = '0;
      modelReset();
      #12;
      compared += 2;
      if (pwm_out !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_pwm: got %b want 0000", pwm_out);
      end
      if (period_end !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_pend: got %b want 0", period_end);
      end
      rst = 1'b0;
      applyStimulus();
   endtask

   task automatic test_edge();
      int pends = 0;
      configure(9, 0, 0, 5, 0, 0, 0);
      enable = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus();
         compared += 4;
         if (pwm_out !== mOut) begin
            mismatched++;
            $display("[TB] FAIL edge_model_pwm clk %0d: got %b want %b", i, pwm_out, mOut);
         end
         if (period_end !== mPend) begin
            mismatched++;
            $display("[TB] FAIL edge_model_pend clk %0d: got %b want %b", i, period_end, mPend);
         end
         if (pwm_out[0] !== (((i - 1) % 10) < 5)) begin
            mismatched++;
            $display("[TB] FAIL edge_pattern clk %0d: got %b", i, pwm_out[0]);
         end
         if (period_end !== (i % 10 == 0)) begin
            mismatched++;
            $display("[TB] FAIL edge_pend_spacing clk %0d: got %b", i, period_end);
         end
         if (period_end) pends++;
      end
      compared++;
      if (pends !== 2) begin
         mismatched++;
         $display("[TB] FAIL edge_pend_count: got %0d want 2", pends);
      end
   endtask

   task automatic test_center();
      int highs = 0;
      int ph;
      configure(5, 1, 0, 0, 2, 0, 0);
      enable = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus();
         ph = (i - 1) % 10;
         compared += 4;
         if (pwm_out !== mOut) begin
            mismatched++;
            $display("[TB] FAIL center_model_pwm clk %0d: got %b want %b", i, pwm_out, mOut);
         end
         if (period_end !== mPend) begin
            mismatched++;
            $display("[TB] FAIL center_model_pend clk %0d: got %b want %b", i, period_end, mPend);
         end
         if (pwm_out[1] !== (ph == 0 || ph == 1 || ph == 9)) begin
            mismatched++;
            $display("[TB] FAIL center_pattern clk %0d: got %b", i, pwm_out[1]);
         end
         if (period_end !== (i % 10 == 0)) begin
            mismatched++;
            $display("[TB] FAIL center_pend clk %0d: got %b", i, period_end);
         end
         if (pwm_out[1]) highs++;
      end
      compared++;
      if (highs !== 6) begin
         mismatched++;
         $display("[TB] FAIL center_high_count: got %0d want 6", highs);
      end
   endtask

   task automatic test_prescale();
      int highs = 0;
      configure(3, 0, 3, 0, 0, 2, 0);
      enable = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         applyStimulus();
         compared += 4;
         if (pwm_out !== mOut) begin
            mismatched++;
            $display("[TB] FAIL psc_model_pwm clk %0d: got %b want %b", i, pwm_out, mOut);
         end
         if (period_end !== mPend) begin
            mismatched++;
            $display("[TB] FAIL psc_model_pend clk %0d: got %b want %b", i, period_end, mPend);
         end
         if (pwm_out[2] !== (((i - 1) % 16) < 8)) begin
            mismatched++;
            $display("[TB] FAIL psc_pattern clk %0d: got %b", i, pwm_out[2]);
         end
         if (period_end !== (i % 16 == 0)) begin
            mismatched++;
            $display("[TB] FAIL psc_pend clk %0d: got %b", i, period_end);
         end
         if (pwm_out[2]) highs++;
      end
      compared++;
      if (highs !== 16) begin
         mismatched++;
         $display("[TB] FAIL psc_high_count: got %0d want 16", highs);
      end
   endtask

   task automatic test_duty_update();
      int  h [3];
      bit  seen = 0;
      int  writeClk;
      int  newDuty;
      int  want [3];
      configure(9, 0, 0, 2, 0, 0, 0);
      enable = 1'b1;
      for (int i = 0; i < 30 && !seen; i++) begin
         applyStimulus();
         seen = period_end;
      end
      compared++;
      if (!seen) begin
         mismatched++;
         $display("[TB] FAIL duty_wait_period_end: got none want pulse within 30 clk");
      end
      for (int pass = 0; pass < 2; pass++) begin
         writeClk = (pass == 0) ? 3 : 10;
         newDuty  = (pass == 0) ? 6 : 3;
         want     = (pass == 0) ? '{2, 6, 6} : '{6, 6, 3};
         h        = '{0, 0, 0};
         for (int j = 1; j <= 30; j++) begin
            if (j == writeClk) begin
               duty_wr_en = 1'b1; duty_wr_ch = 2'd0; duty_wr_data = WIDTH'(newDuty);
            end
            applyStimulus();
            duty_wr_en = 1'b0;
            compared += 3;
            if (pwm_out !== mOut) begin
               mismatched++;
               $display("[TB] FAIL duty_model_pwm pass %0d clk %0d: got %b want %b", pass, j, pwm_out, mOut);
            end
            if (period_end !== mPend) begin
               mismatched++;
               $display("[TB] FAIL duty_model_pend pass %0d clk %0d: got %b want %b", pass, j, period_end, mPend);
            end
            if (period_end !== (j % 10 == 0)) begin
               mismatched++;
               $display("[TB] FAIL duty_pend pass %0d clk %0d: got %b", pass, j, period_end);
            end
            if (pwm_out[0]) h[(j - 1) / 10]++;
         end
         for (int k = 0; k < 3; k++) begin
            compared++;
            if (h[k] !== want[k]) begin
               mismatched++;
               $display("[TB] FAIL duty_period_highs pass %0d period %0d: got %0d want %0d", pass, k, h[k], want[k]);
            end
         end
      end
   endtask

   task automatic test_limits();
      configure(7, 0, 0, 0, 8, 255, 4);
      enable = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         applyStimulus();
         compared += 3;
         if (pwm_out !== mOut) begin
            mismatched++;
            $display("[TB] FAIL limit_model_pwm clk %0d: got %b want %b", i, pwm_out, mOut);
         end
         if (pwm_out[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL limit_duty0_low clk %0d: got %b", i, pwm_out[0]);
         end
         if (pwm_out[2:1] !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL limit_duty_over_high clk %0d: got %b want 11", i, pwm_out[2:1]);
         end
      end
      configure(0, 0, 0, 1, 0, 0, 0);
      enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus();
         compared += 2;
         if (pwm_out[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL limit_p0_high clk %0d: got %b want 1", i, pwm_out[0]);
         end
         if (period_end !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL limit_p0_pend clk %0d: got %b want 1", i, period_end);
         end
      end
   endtask

   task automatic test_enable();
      configure(9, 0, 0, 5, 5, 5, 5);
      enable = 1'b1;
      for (int i = 0; i < 7; i++) applyStimulus();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         compared += 2;
         if (pwm_out !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL enable_off_pwm clk %0d: got %b want 0000", i, pwm_out);
         end
         if (period_end !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL enable_off_pend clk %0d: got %b want 0", i, period_end);
         end
      end
      enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus();
         compared += 2;
         if (pwm_out !== mOut) begin
            mismatched++;
            $display("[TB] FAIL enable_model_pwm clk %0d: got %b want %b", i, pwm_out, mOut);
         end
         if (pwm_out !== ((i <= 5) ? 4'b1111 : 4'b0000)) begin
            mismatched++;
            $display("[TB] FAIL enable_restart clk %0d: got %b", i, pwm_out);
         end
      end
   endtask

   task automatic test_async_reset();
      configure(0, 0, 0, 1, 1, 1, 1);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus();
      #3;
      rst = 1'b1;
      #1;
      modelReset();
      compared += 2;
      if (pwm_out !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL async_rst_pwm: got %b want 0000", pwm_out);
      end
      if (period_end !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL async_rst_pend: got %b want 0", period_end);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      period = 8'd9;
      for (int i = 1; i <= 25; i++) begin
         applyStimulus();
         compared += 3;
         if (pwm_out !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL rst_shadow_cleared clk %0d: got %b want 0000", i, pwm_out);
         end
         if (pwm_out !== mOut) begin
            mismatched++;
            $display("[TB] FAIL rst_model_pwm clk %0d: got %b want %b", i, pwm_out, mOut);
         end
         if (period_end !== mPend) begin
            mismatched++;
            $display("[TB] FAIL rst_model_pend clk %0d: got %b want %b", i, period_end, mPend);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 12; r++) begin
         configure($urandom_range(0, 12), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   $urandom_range(0, 14), $urandom_range(0, 14),
                   $urandom_range(0, 14), $urandom_range(0, 14));
         enable = 1'b1;
         for (int i = 0; i < 60; i++) begin
            duty_wr_en   = ($urandom_range(0, 3) == 0);
            duty_wr_ch   = 2'($urandom_range(0, 3));
            duty_wr_data = WIDTH'($urandom_range(0, 14));
            if ($urandom_range(0, 9) == 0) period = WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) center_mode = ~center_mode;
            enable = ($urandom_range(0, 29) != 0);
            applyStimulus();
            compared += 2;
            if (pwm_out !== mOut) begin
               mismatched++;
               $display("[TB] FAIL random_pwm round %0d clk %0d: got %b want %b", r, i, pwm_out, mOut);
            end
            if (period_end !== mPend) begin
               mismatched++;
               $display("[TB] FAIL random_pend round %0d clk %0d: got %b want %b", r, i, period_end, mPend);
            end
         end
         duty_wr_en = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_edge();
      test_center();
      test_prescale();
      test_duty_update();
      test_limits();
      test_enable();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
